// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the sequential shifter:
//     - op-code constants for the three legal shift operations
//     - FSM state enum used by shift_seq_ctrl
//     - is_shift_op(): true when an op-code names a legal shift
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_SLL = 4'b0100;  // logical left, zero fill from LSB
  localparam logic [3:0] OP_SRL = 4'b0101;  // logical right, zero fill from MSB
  localparam logic [3:0] OP_SRA = 4'b1001;  // arithmetic right, sign fill from MSB

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational one-bit shifter.
//   Ports:
//     i_value  [WIDTH-1:0]  value to shift
//     i_left                1 = shift left (zero into LSB), 0 = shift right
//     i_arith               right shifts only: 1 = copy MSB into MSB, 0 = zero
//     o_value  [WIDTH-1:0]  shifted value
// -----------------------------------------------------------------------------
module shift_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_left,
  input  logic             i_arith,
  output logic [WIDTH-1:0] o_value
);

  logic w_fill;

  // i_arith is ignored on left shifts; the vacated LSB is always zero.
  assign w_fill  = i_arith & i_value[WIDTH-1];
  assign o_value = i_left ? {i_value[WIDTH-2:0], 1'b0}
                          : {w_fill, i_value[WIDTH-1:1]};

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Sequential shifter: accepts one request, shifts the working register one
//   bit per clock for i_shamt clocks, then presents the result until taken.
//
//   Handshake semantics (both sides):
//     A transfer happens at a rising edge where valid && ready are both high.
//     Request side : i_valid / o_ready; o_ready is high only in IDLE, and a
//                    request with i_flush high is never taken.
//     Result side  : o_valid / i_ready; o_valid, o_result and o_illegal stay
//                    constant from the first o_valid cycle until the transfer.
//     i_flush overrides both sides: the FSM returns to IDLE and any pending
//     result is dropped.
//
//   Ports:
//     i_clk, i_rst_n        clock, synchronous active-low reset
//     i_valid, o_ready      request handshake
//     i_oper [3:0]          op-code (OP_SLL / OP_SRL / OP_SRA, else illegal)
//     i_operand [WIDTH-1:0] value to shift
//     i_shamt [SHW-1:0]     shift amount
//     i_flush               synchronous abort
//     o_valid, i_ready      result handshake
//     o_result [WIDTH-1:0]  shifted value (0 outside DONE)
//     o_illegal             op-code was not a shift (0 outside DONE)
//     o_busy                operation in progress (SHIFT or DONE)
// -----------------------------------------------------------------------------
module shift_seq_ctrl
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_oper,
  input  logic [WIDTH-1:0] i_operand,
  input  logic [SHW-1:0]   i_shamt,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal,
  output logic             o_busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic [3:0]       r_op;
  logic             r_illegal;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_work_next;
  logic [SHW-1:0]   w_cnt_next;
  logic [3:0]       w_op_next;
  logic             w_illegal_next;
  logic [WIDTH-1:0] w_step;

  shift_step #(.WIDTH(WIDTH)) u_shift_step (
    .i_value (r_work),
    .i_left  (r_op == OP_SLL),
    .i_arith (r_op == OP_SRA),
    .o_value (w_step)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_work    <= '0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_work    <= w_work_next;
      r_cnt     <= w_cnt_next;
      r_op      <= w_op_next;
      r_illegal <= w_illegal_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_work_next    = r_work;
    w_cnt_next     = r_cnt;
    w_op_next      = r_op;
    w_illegal_next = r_illegal;

    case (r_state)
      ST_IDLE: begin
        if (i_valid && !i_flush) begin
          w_op_next = i_oper;
          if (!is_shift_op(i_oper)) begin
            w_state_next   = ST_DONE;
            w_work_next    = '0;
            w_cnt_next     = '0;
            w_illegal_next = 1'b1;
          end else if (i_shamt == '0) begin
            w_state_next   = ST_DONE;
            w_work_next    = i_operand;
            w_cnt_next     = '0;
            w_illegal_next = 1'b0;
          end else begin
            w_state_next   = ST_SHIFT;
            w_work_next    = i_operand;
            w_cnt_next     = i_shamt;
            w_illegal_next = 1'b0;
          end
        end
      end

      ST_SHIFT: begin
        if (i_flush) begin
          w_state_next   = ST_IDLE;
          w_work_next    = '0;
          w_cnt_next     = '0;
          w_illegal_next = 1'b0;
        end else begin
          w_work_next = w_step;
          // Saturate at zero so the counter can never wrap.
          if (r_cnt != '0) w_cnt_next = r_cnt - SHW'(1);
          if (r_cnt <= SHW'(1)) w_state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        // Flush drops the result; otherwise leave only on the transfer.
        if (i_flush || i_ready) begin
          w_state_next   = ST_IDLE;
          w_work_next    = '0;
          w_cnt_next     = '0;
          w_illegal_next = 1'b0;
        end
      end

      default: begin
        w_state_next   = ST_IDLE;
        w_work_next    = '0;
        w_cnt_next     = '0;
        w_illegal_next = 1'b0;
      end
    endcase
  end

  assign o_ready   = (r_state == ST_IDLE);
  assign o_busy    = (r_state != ST_IDLE);
  assign o_valid   = (r_state == ST_DONE);
  assign o_result  = (r_state == ST_DONE) ? r_work : '0;
  assign o_illegal = (r_state == ST_DONE) ? r_illegal : 1'b0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
//   Directed self-checking bench for shift_seq_ctrl (WIDTH = 32).
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int SW  = 5;
  localparam int MAX_WAIT = 100;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [3:0]    i_oper;
  logic [W-1:0]  i_operand;
  logic [SW-1:0] i_shamt;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_result;
  logic          o_illegal;
  logic          o_busy;

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_oper    (i_oper),
    .i_operand (i_operand),
    .i_shamt   (i_shamt),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_illegal (o_illegal),
    .o_busy    (o_busy)
  );

  // ---------------------------------------------------------------- clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------------------------------------------------------- helpers
  // Advance past the next rising edge; inputs are driven and outputs sampled
  // 1 ns after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one request for one edge, then scramble the request inputs so any
  // dependence on them after acceptance shows up in the result.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] opnd,
                       input logic [SW-1:0] sh, input logic [W-1:0] exp_res);
    chk("ready_before_issue", {63'd0, o_ready}, 64'd1);
    i_valid   = 1'b1;
    i_oper    = op;
    i_operand = opnd;
    i_shamt   = sh;
    exp_q.push_back(exp_res);
    step();
    i_valid   = 1'b0;
    i_oper    = 4'($urandom_range(0, 15));
    i_operand = $urandom;
    i_shamt   = SW'($urandom_range(0, 31));
  endtask

  // Called just after the accept edge k. Counts edges until o_valid, which
  // must be exp_lat, then checks the result against the scoreboard.
  task automatic wait_done(input string tag, input int exp_lat, input logic exp_ill);
    int lat;
    logic [W-1:0] exp_res;
    lat = 0;
    while (!o_valid && lat < MAX_WAIT) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_q.size() > 0) exp_res = exp_q.pop_front();
    else exp_res = 'x;
    chk({tag, "_result"},  {32'd0, o_result},   {32'd0, exp_res});
    chk({tag, "_illegal"}, {63'd0, o_illegal},  {63'd0, exp_ill});
    chk({tag, "_busy"},    {63'd0, o_busy},     64'd1);
    chk({tag, "_ready"},   {63'd0, o_ready},    64'd0);
  endtask

  // Complete the result transfer and confirm the outputs return to idle.
  task automatic take(input string tag);
    i_ready = 1'b1;
    step();
    chk({tag, "_valid_after"},  {63'd0, o_valid},  64'd0);
    chk({tag, "_result_after"}, {32'd0, o_result}, 64'd0);
    chk({tag, "_ready_after"},  {63'd0, o_ready},  64'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] opnd,
                     input logic [SW-1:0] sh, input logic [W-1:0] exp_res,
                     input int exp_lat, input logic exp_ill);
    issue(op, opnd, sh, exp_res);
    wait_done(tag, exp_lat, exp_ill);
    take(tag);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int saw_valid;

    i_rst_n   = 1'b0;
    i_valid   = 1'b0;
    i_oper    = 4'd0;
    i_operand = '0;
    i_shamt   = '0;
    i_flush   = 1'b0;
    i_ready   = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_valid",   {63'd0, o_valid},   64'd0);
    chk("rst_result",  {32'd0, o_result},  64'd0);
    chk("rst_illegal", {63'd0, o_illegal}, 64'd0);
    chk("rst_busy",    {63'd0, o_busy},    64'd0);
    chk("rst_ready",   {63'd0, o_ready},   64'd1);
    i_rst_n = 1'b1;
    step();

    // Main function, directed vectors
    run("sll_1_by4",      OP_SLL, 32'h0000_0001, 5'd4,  32'h0000_0010, 4,  1'b0);
    run("sra_msb_by31",   OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 31, 1'b0);
    run("srl_msb_by31",   OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 31, 1'b0);
    run("sll_edge_by31",  OP_SLL, 32'h8000_0001, 5'd31, 32'h8000_0000, 31, 1'b0);
    run("srl_zero_shamt", OP_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0,  1'b0);
    run("illegal_op",     4'b0011, 32'hDEAD_BEEF, 5'd5, 32'h0000_0000, 0, 1'b1);
    run("sra_pos_by4",    OP_SRA, 32'h7000_0000, 5'd4,  32'h0700_0000, 4,  1'b0);
    run("srl_by1",        OP_SRL, 32'hF000_000F, 5'd1,  32'h7800_0007, 1,  1'b0);

    // Back-pressure: result held, second request blocked until after transfer
    i_ready = 1'b0;
    issue(OP_SLL, 32'h0000_0001, 5'd8, 32'h0000_0100);
    wait_done("hold", 8, 1'b0);
    i_valid   = 1'b1;
    i_oper    = OP_SRL;
    i_operand = 32'h0000_0080;
    i_shamt   = 5'd3;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_valid",  {63'd0, o_valid},  64'd1);
      chk("hold_result", {32'd0, o_result}, 64'h100);
      chk("hold_ready",  {63'd0, o_ready},  64'd0);
    end
    i_ready = 1'b1;
    step();  // transfer edge: i_valid is high but must not be accepted
    chk("hs_no_accept_busy",  {63'd0, o_busy},  64'd0);
    chk("hs_no_accept_ready", {63'd0, o_ready}, 64'd1);
    exp_q.push_back(32'h0000_0010);
    step();  // accepted here
    i_valid = 1'b0;
    wait_done("second_req", 3, 1'b0);
    take("second_req");

    // Flush while idle with a request present: not accepted
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_oper  = OP_SLL;
    i_shamt = 5'd2;
    step();
    i_valid = 1'b0;
    i_flush = 1'b0;
    chk("flush_idle_busy", {63'd0, o_busy}, 64'd0);

    // Flush at the second SHIFT cycle of a shamt-10 request
    issue(OP_SLL, 32'h0000_0003, 5'd10, 32'h0);
    void'(exp_q.pop_back());
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_shift_busy",  {63'd0, o_busy},  64'd0);
    chk("flush_shift_ready", {63'd0, o_ready}, 64'd1);
    saw_valid = 0;
    for (int c = 0; c < 14; c++) begin
      if (o_valid) saw_valid++;
      step();
    end
    chk("flush_shift_no_valid", 64'(saw_valid), 64'd0);

    // Flush while DONE: result dropped
    i_ready = 1'b0;
    issue(OP_SRL, 32'h0000_0010, 5'd1, 32'h0000_0008);
    wait_done("flush_done", 1, 1'b0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_ready = 1'b1;
    chk("flush_done_valid", {63'd0, o_valid}, 64'd0);
    chk("flush_done_busy",  {63'd0, o_busy},  64'd0);

    // Reset in the middle of SHIFT
    issue(OP_SRA, 32'h8000_0000, 5'd10, 32'h0);
    void'(exp_q.pop_back());
    step();
    step();
    i_rst_n = 1'b0;
    step();
    chk("rst_mid_valid",   {63'd0, o_valid},   64'd0);
    chk("rst_mid_result",  {32'd0, o_result},  64'd0);
    chk("rst_mid_illegal", {63'd0, o_illegal}, 64'd0);
    chk("rst_mid_busy",    {63'd0, o_busy},    64'd0);
    chk("rst_mid_ready",   {63'd0, o_ready},   64'd1);
    chk("rst_mid_cnt",     64'(dut.r_cnt),     64'd0);
    chk("rst_mid_work",    {32'd0, dut.r_work}, 64'd0);
    i_rst_n = 1'b1;
    saw_valid = 0;
    for (int c = 0; c < 14; c++) begin
      if (o_valid) saw_valid++;
      step();
    end
    chk("rst_mid_no_valid", 64'(saw_valid), 64'd0);

    // Recovery after reset
    run("after_rst_sll", OP_SLL, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 8, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
